// File: rtl/fft_input_reorder_pkg.sv
// fft_input_reorder_pkg: default sizes, complex sample type and bit-reversal helper
// shared by the fft_input_reorder block.
package fft_pkg;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_N_POINTS = 4;
  localparam int LOG2N = $clog2(DEF_N_POINTS);
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] re;
    logic [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int log2n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < log2n) r[i] = idx[log2n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_input_reorder_bank.sv
// fft_reorder_bank: N-entry sample store with one write port and two combinational
// read ports; contents are deliberately not reset.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b
);
  logic [W-1:0] r_mem [N];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/fft_input_reorder.sv
// fft_input_reorder: buffers a frame of complex samples and emits butterfly operand pairs
// in bit-reversed order. Define FFT_REORDER_PINGPONG_EN for two overlapping banks.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_POINTS = DEF_N_POINTS,
  localparam int LG = $clog2(N_POINTS),
  localparam int PW = LG - 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] real_in_0,
  output logic [DATA_WIDTH-1:0] imag_in_0,
  output logic [DATA_WIDTH-1:0] real_in_1,
  output logic [DATA_WIDTH-1:0] imag_in_1,
  output logic [PW-1:0]         pair_idx,
  output logic                  out_last
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } sample_t;
`ifdef FFT_REORDER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  logic [LG-1:0] r_wr_cnt;
  logic [PW-1:0] r_rd_cnt;
  logic [1:0]    r_full;
  logic          r_wr_bank, r_rd_bank;
  logic          w_wr, w_rd, w_wr_last, w_rd_last;
  logic [1:0]    w_set, w_clr;
  logic [LG-1:0] w_addr_a, w_addr_b;
  sample_t       w_a [2];
  sample_t       w_b [2];
  sample_t       w_sa, w_sb;
  assign in_ready  = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;
  assign w_wr_last = r_wr_cnt == LG'(N_POINTS - 1);
  assign w_rd_last = r_rd_cnt == PW'(N_POINTS / 2 - 1);
  assign w_set     = {2{w_wr && w_wr_last}} & (r_wr_bank ? 2'b10 : 2'b01);
  assign w_clr     = {2{w_rd && w_rd_last}} & (r_rd_bank ? 2'b10 : 2'b01);
  // bitrev(2p) always has a clear MSB, so the partner index is just that bit set
  assign w_addr_a  = LG'(bitrev(16'({r_rd_cnt, 1'b0}), LG));
  assign w_addr_b  = {1'b1, w_addr_a[LG-2:0]};
`ifdef FFT_REORDER_PINGPONG_EN
  fft_reorder_bank #(.W(2*DATA_WIDTH), .N(N_POINTS)) u_bank0 (
    .clk(CLK), .i_we(w_wr && !r_wr_bank), .i_waddr(r_wr_cnt), .i_wdata({in_real, in_imag}),
    .i_raddr_a(w_addr_a), .i_raddr_b(w_addr_b), .o_rdata_a(w_a[0]), .o_rdata_b(w_b[0])
  );
  fft_reorder_bank #(.W(2*DATA_WIDTH), .N(N_POINTS)) u_bank1 (
    .clk(CLK), .i_we(w_wr && r_wr_bank), .i_waddr(r_wr_cnt), .i_wdata({in_real, in_imag}),
    .i_raddr_a(w_addr_a), .i_raddr_b(w_addr_b), .o_rdata_a(w_a[1]), .o_rdata_b(w_b[1])
  );
`else
  fft_reorder_bank #(.W(2*DATA_WIDTH), .N(N_POINTS)) u_bank0 (
    .clk(CLK), .i_we(w_wr), .i_waddr(r_wr_cnt), .i_wdata({in_real, in_imag}),
    .i_raddr_a(w_addr_a), .i_raddr_b(w_addr_b), .o_rdata_a(w_a[0]), .o_rdata_b(w_b[0])
  );
  assign w_a[1] = w_a[0];
  assign w_b[1] = w_b[0];
`endif
  assign w_sa      = w_a[r_rd_bank];
  assign w_sb      = w_b[r_rd_bank];
  assign real_in_0 = out_valid ? w_sa.re : '0;
  assign imag_in_0 = out_valid ? w_sa.im : '0;
  assign real_in_1 = out_valid ? w_sb.re : '0;
  assign imag_in_1 = out_valid ? w_sb.im : '0;
  assign pair_idx  = out_valid ? r_rd_cnt : '0;
  assign out_last  = out_valid && w_rd_last;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_wr) r_wr_cnt <= r_wr_cnt + LG'(1);
      if (w_rd) r_rd_cnt <= r_rd_cnt + PW'(1);
      if (w_wr && w_wr_last) r_wr_bank <= r_wr_bank ^ PP;
      if (w_rd && w_rd_last) r_rd_bank <= r_rd_bank ^ PP;
      r_full <= (r_full | w_set) & ~w_clr;
    end
endmodule
